seq_multiplier_n_bit: RTL and testbench
=======================================

SEQ_MULTIPLIER_N_BIT -- requirements
Module: seq_multiplier_n_bit

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, synchronous and active-low.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 Multiplicand  input  WIDTH  operand M; sampled with Start.
REQ-007 Multiplier  input  WIDTH  operand Q; sampled with Start.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  one-cycle pulse: Product valid.
REQ-010 Product  output  2*WIDTH  {A,B} register pair; held until next accepted Start.
REQ-011 X  output  1  sign/carry extension bit of A, for debug display.

Function
REQ-012 States SHALL be IDLE, RUN, DONE.
REQ-013 IDLE with Start=1 SHALL accept at that edge: A<=0, X<=0, B<=Multiplier, M_reg<=Multiplicand, mode_reg<=Signed_Mode, count<=0, state<=RUN.
REQ-014 Each RUN cycle SHALL perform one add-and-shift step; step index = count (0..WIDTH-1).
REQ-015 Step: if B[0]=1, {X,A} <= (WIDTH+1)-bit sum of ext(A) and ext(M_reg), else {X,A} unchanged; then {X,A,B} shifted right by one in the same edge.
REQ-016 ext(): sign-extend when mode_reg=1, zero-extend when mode_reg=0.
REQ-017 Signed mode, step WIDTH-1 with B[0]=1: SHALL subtract ext(M_reg) instead of add.
REQ-018 Shift-in to X: copy of new X when mode_reg=1 (arithmetic); 0 when mode_reg=0.
REQ-019 After step WIDTH-1, state<=DONE; Done=1 for exactly the DONE cycle; then state<=IDLE.
REQ-020 Latency: Done high in the cycle starting WIDTH+1 rising edges after the accept edge (accept edge + WIDTH steps).
REQ-021 Start SHALL be ignored in RUN and DONE; no queuing.
REQ-022 Operand inputs SHALL be ignored after the accept edge; changing them mid-operation has no effect.
REQ-023 Product SHALL be exact: signed result in [-2^(2W-2), 2^(2W-2)], unsigned up to (2^W-1)^2; no overflow possible.
REQ-024 Intermediate Product/X visible during RUN; only Done marks validity.

Reset
REQ-025 Reset_n=0 at an edge SHALL force state=IDLE, A=0, B=0, X=0, M_reg=0, mode_reg=0, count=0, Done=0, Busy=0, overriding Start in the same cycle.
REQ-026 Reset_n=0 mid-RUN SHALL abort without a Done pulse; Product=0 after.
REQ-027 No output SHALL be X/undefined after one reset edge.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and a count-width function based on $clog2(WIDTH).
REQ-029 Arithmetic SHALL be one sub-module, adder_subtractor_n_bit (WIDTH+1-bit add/subtract, parameter WIDTH).
REQ-030 Control (FSM + counter) and datapath in the top module; no internal synchroniser (inputs already synchronous).

Verification (WIDTH=8 unless stated)
REQ-031 Signed 7 x -3 (0x07, 0xFD) -> Done at accept+9 edges, Product=0xFFEB, Busy high 9 cycles.
REQ-032 Unsigned 0xFF x 0xFF -> Product=0xFE01; signed 0xFF x 0xFF -> Product=0x0001.
REQ-033 Signed -128 x -128 (0x80,0x80) -> Product=0x4000; signed -128 x 127 -> 0xC080.
REQ-034 Start held high through RUN, operands changed mid-run -> single Done, result of original operands, next accept only from IDLE.
REQ-035 Reset_n low at step 4 -> next cycle Busy=0, Product=0, no Done; fresh Start 3 x 5 -> 0x000F.
REQ-036 WIDTH=16 signed 0x8000 x 0x0002 -> Done at accept+17, Product=0xFFFF0000.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential multiplier
package mult_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter: must hold 0..width-1, and never be zero bits wide
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/adder_subtractor_n_bit.sv
// rtl/adder_subtractor_n_bit.sv - (WIDTH+1)-bit adder/subtractor
//
// Ports:
//   a, b  : WIDTH+1-bit operands (already extended by the caller)
//   sub   : 1 = y = a - b, 0 = y = a + b
//   y     : WIDTH+1-bit result, carry/borrow out of the top bit discarded
module adder_subtractor_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/seq_multiplier_n_bit.sv
// rtl/seq_multiplier_n_bit.sv - sequential add-and-shift multiplier, signed or unsigned
//
// Ports:
//   CLK          : clock, rising edge
//   Reset_n      : synchronous active-low reset
//   Start        : request, accepted only in IDLE
//   Signed_Mode  : 1 = two's-complement operands, captured with Start
//   Multiplicand : operand M, captured with Start
//   Multiplier   : operand Q, captured with Start
//   Busy         : high whenever not IDLE
//   Done         : one-cycle pulse, Product valid
//   Product      : {A,B} register pair, held until the next accepted Start
//   X            : extension bit above A
module seq_multiplier_n_bit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 X
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  m_reg;
  logic              x_reg;
  logic              mode_reg;
  logic [CW-1:0]     count;

  logic              last_step;
  logic              do_sub;
  logic              shift_in;
  logic [WIDTH:0]    a_ext;
  logic [WIDTH:0]    m_ext;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    step_xa;

  assign last_step = (count == LAST_COUNT);

  // Operands widened by one bit so the partial sum can never overflow
  assign a_ext = mode_reg ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
  assign m_ext = mode_reg ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};

  // In two's complement the multiplier MSB carries weight -2^(W-1),
  // so its partial product is subtracted rather than added
  assign do_sub = mode_reg & last_step;

  adder_subtractor_n_bit #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (a_ext),
    .b   (m_ext),
    .sub (do_sub),
    .y   (sum)
  );

  assign step_xa  = b_reg[0] ? sum : {x_reg, a_reg};
  // Arithmetic shift keeps the sign in signed mode; logical otherwise
  assign shift_in = mode_reg & step_xa[WIDTH];

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and step counter
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      m_reg    <= '0;
      x_reg    <= 1'b0;
      mode_reg <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg    <= '0;
            x_reg    <= 1'b0;
            b_reg    <= Multiplier;
            m_reg    <= Multiplicand;
            mode_reg <= Signed_Mode;
            count    <= '0;
          end
        end
        RUN: begin
          // {X,A,B} shifted right by one with the freshly added {X,A}
          {x_reg, a_reg, b_reg} <= {shift_in, step_xa, b_reg[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state != IDLE);
  assign Done    = (state == DONE);
  assign Product = {a_reg, b_reg};
  assign X       = x_reg;

endmodule

// File: tb/tb_seq_multiplier_n_bit.sv
// tb/tb_seq_multiplier_n_bit.sv - directed self-checking bench for seq_multiplier_n_bit
module tb_seq_multiplier_n_bit;

  logic        CLK = 1'b0;
  logic        Reset_n;

  logic        start8, mode8;
  logic [7:0]  mcand8, mplier8;
  logic        busy8, done8, x8;
  logic [15:0] product8;

  logic        start16, mode16;
  logic [15:0] mcand16, mplier16;
  logic        busy16, done16, x16;
  logic [31:0] product16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  seq_multiplier_n_bit #(.WIDTH(8)) dut8 (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .Start        (start8),
    .Signed_Mode  (mode8),
    .Multiplicand (mcand8),
    .Multiplier   (mplier8),
    .Busy         (busy8),
    .Done         (done8),
    .Product      (product8),
    .X            (x8)
  );

  seq_multiplier_n_bit #(.WIDTH(16)) dut16 (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .Start        (start16),
    .Signed_Mode  (mode16),
    .Multiplicand (mcand16),
    .Multiplier   (mplier16),
    .Busy         (busy16),
    .Done         (done16),
    .Product      (product16),
    .X            (x16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Steps edges until Done is seen (bounded); lat = edges since entry,
  // busy_cnt = sampled cycles with Busy high including the entry sample
  task automatic wait_done(input bit sel16, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (sel16 ? busy16 : busy8) busy_cnt++;
      if (sel16 ? done16 : done8) break;
      tick();
      lat++;
    end
  endtask

  task automatic run8(input string tag, input logic mode, input logic [7:0] m,
                      input logic [7:0] q, input logic [15:0] exp_p);
    int lat, bc;
    start8 = 1'b1; mode8 = mode; mcand8 = m; mplier8 = q;
    tick();
    start8 = 1'b0;
    wait_done(1'b0, lat, bc);
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " busy cycles"}, 64'(bc), 64'd9);
    check({tag, " product"}, 64'(product8), 64'(exp_p));
    tick();
    check({tag, " done pulse width"}, 64'(done8), 64'd0);
    check({tag, " idle busy"}, 64'(busy8), 64'd0);
    check({tag, " product held"}, 64'(product8), 64'(exp_p));
  endtask

  initial begin
    int lat, bc;

    Reset_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; mcand8 = '0; mplier8 = '0;
    start16 = 1'b0; mode16 = 1'b0; mcand16 = '0; mplier16 = '0;
    tick();
    tick();
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset product", 64'(product8), 64'd0);
    check("reset x", 64'(x8), 64'd0);
    check("reset product16", 64'(product16), 64'd0);
    Reset_n = 1'b1;
    tick();

    run8("s 7x-3",      1'b1, 8'h07, 8'hFD, 16'hFFEB);
    run8("u 7x253",     1'b0, 8'h07, 8'hFD, 16'h06EB);
    run8("u FFxFF",     1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("s FFxFF",     1'b1, 8'hFF, 8'hFF, 16'h0001);
    run8("s -128x-128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("s -128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);

    // Start held high, operands changed mid-run
    start8 = 1'b1; mode8 = 1'b1; mcand8 = 8'h07; mplier8 = 8'hFD;
    tick();
    check("hold accept busy", 64'(busy8), 64'd1);
    tick(); tick(); tick();
    mode8 = 1'b0; mcand8 = 8'hFF; mplier8 = 8'hFF;
    wait_done(1'b0, lat, bc);
    check("hold latency", 64'(lat + 3), 64'd8);
    check("hold product", 64'(product8), 64'hFFEB);
    tick();
    check("hold no second done", 64'(done8), 64'd0);
    check("hold idle", 64'(busy8), 64'd0);
    check("hold product kept", 64'(product8), 64'hFFEB);
    tick();
    check("hold reaccept busy", 64'(busy8), 64'd1);
    check("hold reaccept load", 64'(product8), 64'h00FF);
    start8 = 1'b0;
    wait_done(1'b0, lat, bc);
    check("hold second product", 64'(product8), 64'hFE01);
    tick();

    // Reset mid-run at step 4, with Start asserted to show reset wins
    start8 = 1'b1; mode8 = 1'b1; mcand8 = 8'h07; mplier8 = 8'hFD;
    tick();
    tick(); tick(); tick(); tick();
    Reset_n = 1'b0;
    tick();
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort product", 64'(product8), 64'd0);
    check("abort x", 64'(x8), 64'd0);
    tick();
    check("reset over start", 64'(busy8), 64'd0);
    Reset_n = 1'b1;
    start8 = 1'b0;
    tick();
    check("after abort no done", 64'(done8), 64'd0);
    run8("u 3x5", 1'b0, 8'h03, 8'h05, 16'h000F);

    // WIDTH=16 signed 0x8000 x 2
    start16 = 1'b1; mode16 = 1'b1; mcand16 = 16'h8000; mplier16 = 16'h0002;
    tick();
    start16 = 1'b0;
    wait_done(1'b1, lat, bc);
    check("w16 latency", 64'(lat), 64'd16);
    check("w16 busy cycles", 64'(bc), 64'd17);
    check("w16 product", 64'(product16), 64'hFFFF0000);
    tick();
    check("w16 done pulse width", 64'(done16), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
